// File: rtl/xpar_monitor.sv
`timescale 1ns/1ps
// xpar_monitor: harness block on the picoVersat parallel interface.
// Serves core reads from a host-loadable response memory, mirrors and logs
// core writes, and measures run length from start to trap with a watchdog.
module xpar_monitor #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned LOG_DEPTH_W = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  timeout_lim,
    input  logic              trap,
    input  logic [ADDR_W-1:0] par_addr,
    input  logic              par_we,
    input  logic [DATA_W-1:0] par_out,
    output logic [DATA_W-1:0] par_in,
    input  logic              host_we,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              log_pop,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    output logic              log_overflow,
    output logic [CNT_W-1:0]  cycles,
    output logic [1:0]        state
);

    localparam int unsigned MemWords = 2 ** ADDR_W;
    localparam int unsigned LogWords = 2 ** LOG_DEPTH_W;
    localparam int unsigned EntW     = ADDR_W + DATA_W;
    localparam logic [LOG_DEPTH_W:0] LogFull = {1'b1, {LOG_DEPTH_W{1'b0}}};

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StDone    = 2'b10,
        StTimeout = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cycles_q, cycles_d;
    logic [CNT_W-1:0]       cnt_inc;

    logic [DATA_W-1:0]      resp_mem_q   [MemWords];
    logic [DATA_W-1:0]      resp_mem_d   [MemWords];
    logic [DATA_W-1:0]      mirror_mem_q [MemWords];
    logic [DATA_W-1:0]      mirror_mem_d [MemWords];
    logic [EntW-1:0]        log_mem_q    [LogWords];
    logic [EntW-1:0]        log_mem_d    [LogWords];

    logic [LOG_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH_W:0]   log_cnt_q, log_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   log_empty, log_full;
    logic                   push_req, do_push, do_pop;

    logic [DATA_W-1:0]      par_in_q, par_in_d;
    logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;

    // Run state machine and cycle counter; start always restarts a run.
    always_comb begin
        cnt_inc  = cycles_q + CNT_W'(1);
        state_d  = state_q;
        cycles_d = cycles_q;
        if (start) begin
            state_d  = StRun;
            cycles_d = '0;
        end else if (state_q == StRun) begin
            if (!(&cycles_q)) begin
                cycles_d = cnt_inc;
            end
            // Trap has priority over the watchdog. A saturated counter wraps
            // cnt_inc to zero, which never matches a non-zero limit.
            if (trap) begin
                state_d = StDone;
            end else if ((timeout_lim != '0) && (cnt_inc == timeout_lim)) begin
                state_d = StTimeout;
            end
        end
    end

    // Memory write ports: host loads responses, core writes land in the mirror.
    always_comb begin
        resp_mem_d   = resp_mem_q;
        mirror_mem_d = mirror_mem_q;
        if (host_we) begin
            resp_mem_d[host_addr] = host_wdata;
        end
        if (par_we) begin
            mirror_mem_d[par_addr] = par_out;
        end
    end

    // Registered read ports; reads see pre-write contents on collisions.
    always_comb begin
        par_in_d     = resp_mem_q[par_addr];
        host_rdata_d = host_sel ? mirror_mem_q[host_addr] : resp_mem_q[host_addr];
    end

    // Show-ahead write log; start flushes it and drops any coinciding push.
    always_comb begin
        log_empty  = (log_cnt_q == '0);
        log_full   = (log_cnt_q == LogFull);
        do_pop     = log_pop && !log_empty && !start;
        push_req   = par_we && (state_q == StRun) && !start;
        // A pop in the same cycle frees the slot a full-log push needs.
        do_push    = push_req && (!log_full || do_pop);
        log_mem_d  = log_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        log_cnt_d  = log_cnt_q;
        overflow_d = overflow_q;
        if (start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            log_cnt_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                log_mem_d[wr_ptr_q] = {par_addr, par_out};
                wr_ptr_d            = wr_ptr_q + LOG_DEPTH_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + LOG_DEPTH_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   log_cnt_d = log_cnt_q + (LOG_DEPTH_W + 1)'(1);
                2'b01:   log_cnt_d = log_cnt_q - (LOG_DEPTH_W + 1)'(1);
                default: log_cnt_d = log_cnt_q;
            endcase
            if (push_req && !do_push) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control and read-data registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cycles_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            log_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            par_in_q     <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            log_cnt_q    <= log_cnt_d;
            overflow_q   <= overflow_d;
            par_in_q     <= par_in_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        resp_mem_q   <= resp_mem_d;
        mirror_mem_q <= mirror_mem_d;
        log_mem_q    <= log_mem_d;
    end

    assign par_in                = par_in_q;
    assign host_rdata            = host_rdata_q;
    assign log_valid             = !log_empty;
    assign {log_addr, log_data}  = log_mem_q[rd_ptr_q];
    assign log_overflow          = overflow_q;
    assign cycles                = cycles_q;
    assign state                 = state_q;

endmodule

// File: tb/tb_xpar_monitor.sv
`timescale 1ns/1ps
// Bench for xpar_monitor: directed scenarios plus a randomized run, all
// checked against a queue/array reference model of the monitor.
module tb_xpar_monitor;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LDW = 4;
    localparam int CW = 32;
    localparam int LOGN = 2 ** LDW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] timeout_lim = '0;
    logic          trap = 1'b0;
    logic [AW-1:0] par_addr = '0;
    logic          par_we = 1'b0;
    logic [DW-1:0] par_out = '0;
    logic [DW-1:0] par_in;
    logic          host_we = 1'b0;
    logic          host_sel = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic          log_pop = 1'b0;
    logic          log_valid;
    logic [AW-1:0] log_addr;
    logic [DW-1:0] log_data;
    logic          log_overflow;
    logic [CW-1:0] cycles;
    logic [1:0]    state;

    xpar_monitor #(
        .DATA_W(DW), .ADDR_W(AW), .LOG_DEPTH_W(LDW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .timeout_lim(timeout_lim), .trap(trap),
        .par_addr(par_addr), .par_we(par_we), .par_out(par_out), .par_in(par_in),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .log_pop(log_pop),
        .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
        .log_overflow(log_overflow), .cycles(cycles), .state(state)
    );

    always #5 clk = ~clk;

    typedef logic [AW+DW-1:0] ent_t;

    int checks = 0;
    int failures = 0;

    // Reference model: state as the spec's 2-bit code, run length as a plain integer.
    logic [DW-1:0] m_resp [LOGN];
    logic [DW-1:0] m_mirror [LOGN];
    ent_t          m_log [$];
    bit            m_ovf = 0;
    int            m_st = 0;
    longint        m_cyc = 0;
    logic [DW-1:0] e_par_in = '0;
    logic [DW-1:0] e_host_rdata = '0;

    // Apply current inputs to the model, then advance one clock and settle.
    task automatic cycle();
        longint n;
        e_par_in     = m_resp[par_addr];
        e_host_rdata = host_sel ? m_mirror[host_addr] : m_resp[host_addr];
        if (host_we) m_resp[host_addr] = host_wdata;
        if (par_we) m_mirror[par_addr] = par_out;
        if (start) begin
            m_log.delete();
            m_ovf = 0;
        end else begin
            if (log_pop && m_log.size() > 0) void'(m_log.pop_front());
            if (par_we && m_st == 1) begin
                if (m_log.size() < LOGN) m_log.push_back({par_addr, par_out});
                else m_ovf = 1;
            end
        end
        if (start) begin
            m_st  = 1;
            m_cyc = 0;
        end else if (m_st == 1) begin
            n = m_cyc + 1;
            if (trap) m_st = 2;
            else if (timeout_lim != 0 && n == longint'(timeout_lim)) m_st = 3;
            m_cyc = (n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; trap = 0; par_we = 0; host_we = 0; log_pop = 0; host_sel = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        #1;
        m_st = 0; m_cyc = 0; m_log.delete(); m_ovf = 0;
        e_par_in = '0; e_host_rdata = '0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic init_mems();
        for (int i = 0; i < LOGN; i++) begin
            host_we = 1; host_addr = AW'(i); host_wdata = $urandom;
            par_we = 1; par_addr = AW'(i); par_out = $urandom;
            cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, cycles, log_valid, log_overflow, par_in, host_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_por: state=%0d cycles=%0d valid=%0b ovf=%0b par_in=%h rdata=%h",
                     state, cycles, log_valid, log_overflow, par_in, host_rdata);
        end
        rst = 1;
        init_mems();
        par_addr = 2; host_addr = 2;
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 57; i++) begin
            par_we = (i == 10 || i == 20 || i == 30);
            par_out = $urandom;
            cycle();
        end
        par_we = 0;
        checks++;
        if (cycles !== 57 || state !== 2'd1 || log_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_prerun: cycles=%0d state=%0d valid=%0b want 57 1 1",
                     cycles, state, log_valid);
        end
        #2;
        rst = 0;
        #1;
        checks++;
        if ({state, cycles, log_valid, log_overflow, par_in, host_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_async: state=%0d cycles=%0d valid=%0b ovf=%0b par_in=%h rdata=%h",
                     state, cycles, log_valid, log_overflow, par_in, host_rdata);
        end
        m_st = 0; m_cyc = 0; m_log.delete(); m_ovf = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_par_read();
        host_we = 1; host_addr = 3; host_wdata = 32'hDEADBEEF;
        cycle();
        host_we = 0; par_addr = 3; host_sel = 0;
        cycle();
        checks++;
        if (par_in !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL par_read: got %h want deadbeef", par_in);
        end
        host_we = 1; host_wdata = 32'h1;
        cycle();
        host_we = 0;
        checks++;
        if (par_in !== 32'hDEADBEEF || host_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL par_collide_old: par_in=%h rdata=%h want deadbeef", par_in, host_rdata);
        end
        cycle();
        checks++;
        if (par_in !== 32'h1 || host_rdata !== 32'h1) begin
            failures++;
            $display("FAIL par_collide_new: par_in=%h rdata=%h want 1", par_in, host_rdata);
        end
    endtask

    task automatic test_trap();
        timeout_lim = 0;
        start = 1; cycle(); start = 0;
        repeat (99) cycle();
        trap = 1; cycle(); trap = 0;
        checks++;
        if (state !== 2'd2 || cycles !== 100) begin
            failures++;
            $display("FAIL trap_done: state=%0d cycles=%0d want 2 100", state, cycles);
        end
        repeat (5) cycle();
        checks++;
        if (state !== 2'd2 || cycles !== 100) begin
            failures++;
            $display("FAIL trap_hold: state=%0d cycles=%0d want 2 100", state, cycles);
        end
    endtask

    task automatic test_timeout();
        timeout_lim = 20;
        start = 1; cycle(); start = 0;
        repeat (19) cycle();
        checks++;
        if (state !== 2'd1 || cycles !== 19) begin
            failures++;
            $display("FAIL timeout_pre: state=%0d cycles=%0d want 1 19", state, cycles);
        end
        cycle();
        checks++;
        if (state !== 2'd3 || cycles !== 20) begin
            failures++;
            $display("FAIL timeout_hit: state=%0d cycles=%0d want 3 20", state, cycles);
        end
        cycle();
        checks++;
        if (cycles !== 20) begin
            failures++;
            $display("FAIL timeout_hold: cycles=%0d want 20", cycles);
        end
        start = 1; cycle(); start = 0;
        repeat (19) cycle();
        trap = 1; cycle(); trap = 0;
        checks++;
        if (state !== 2'd2 || cycles !== 20) begin
            failures++;
            $display("FAIL timeout_trap_tie: state=%0d cycles=%0d want 2 20", state, cycles);
        end
        timeout_lim = 0;
    endtask

    task automatic test_log_overflow();
        for (int pass = 0; pass < 2; pass++) begin
            ent_t exp [$];
            start = 1; cycle(); start = 0;
            for (int i = 0; i < LOGN + 1; i++) begin
                par_we = 1; par_addr = AW'($urandom); par_out = $urandom;
                exp.push_back({par_addr, par_out});
                log_pop = (pass == 1 && i == LOGN);
                cycle();
            end
            par_we = 0; log_pop = 0;
            if (pass == 1) void'(exp.pop_front());
            checks++;
            if (log_overflow !== (pass == 0)) begin
                failures++;
                $display("FAIL log_ovf_p%0d: got %0b want %0b", pass, log_overflow, pass == 0);
            end
            for (int i = 0; i < LOGN; i++) begin
                checks++;
                if (log_valid !== 1'b1 || {log_addr, log_data} !== exp[i]) begin
                    failures++;
                    $display("FAIL log_entry_p%0d_%0d: valid=%0b got %h want %h",
                             pass, i, log_valid, {log_addr, log_data}, exp[i]);
                end
                log_pop = 1;
                cycle();
            end
            log_pop = 0;
            checks++;
            if (log_valid !== 1'b0) begin
                failures++;
                $display("FAIL log_drained_p%0d: valid=%0b want 0", pass, log_valid);
            end
        end
    endtask

    task automatic test_idle_write();
        do_reset();
        par_we = 1; par_addr = 5; par_out = 32'h42;
        cycle();
        par_we = 0; host_sel = 1; host_addr = 5;
        cycle();
        checks++;
        if (host_rdata !== 32'h42 || log_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_write: rdata=%h valid=%0b want 42 0", host_rdata, log_valid);
        end
        host_sel = 0;
    endtask

    task automatic test_random();
        timeout_lim = ($urandom_range(0, 1) == 0) ? 0 : CW'($urandom_range(60, 200));
        start = 1; cycle();
        for (int i = 0; i < 700; i++) begin
            start      = ($urandom_range(0, 99) == 0) || (m_st != 1 && $urandom_range(0, 19) == 0);
            trap       = ($urandom_range(0, 59) == 0);
            par_we     = $urandom_range(0, 1);
            par_addr   = AW'($urandom);
            par_out    = $urandom;
            host_we    = ($urandom_range(0, 3) == 0);
            host_sel   = $urandom_range(0, 1);
            host_addr  = AW'($urandom);
            host_wdata = $urandom;
            log_pop    = ($urandom_range(0, 9) < 3);
            cycle();
            checks++;
            if (par_in !== e_par_in || host_rdata !== e_host_rdata) begin
                failures++;
                $display("FAIL rnd_read_%0d: par_in=%h/%h rdata=%h/%h (got/want)",
                         i, par_in, e_par_in, host_rdata, e_host_rdata);
            end
            checks++;
            if (state !== 2'(m_st) || cycles !== m_cyc[CW-1:0]) begin
                failures++;
                $display("FAIL rnd_run_%0d: state=%0d/%0d cycles=%0d/%0d (got/want)",
                         i, state, m_st, cycles, m_cyc);
            end
            checks++;
            if (log_valid !== (m_log.size() > 0) || log_overflow !== m_ovf ||
                (m_log.size() > 0 && {log_addr, log_data} !== m_log[0])) begin
                failures++;
                $display("FAIL rnd_log_%0d: valid=%0b ovf=%0b head=%h want size=%0d ovf=%0b",
                         i, log_valid, log_overflow, {log_addr, log_data}, m_log.size(), m_ovf);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_par_read();
        test_trap();
        test_timeout();
        test_log_overflow();
        test_idle_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
